// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Request/acknowledge bus for single data-memory accesses.
interface mem_access_stage_if;
    // Handshake: mem_req is the valid. Once it rises, mem_we/mem_addr/mem_wdata/mem_wmask
    // stay stable until the cycle mem_ack (the ready) is high; a transfer completes on that
    // edge, and for reads mem_rdata must be valid in the same ack cycle. mem_ack without
    // mem_req is ignored.
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over the req/ack bus, stalls the pipe while busy,
// and registers the MEM_WB bundle. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        dbg,
    input  logic [31:0] EX_MEM_alures,
    input  logic [31:0] EX_MEM_storedata,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_regwrite,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic [2:0]  EX_MEM_funct3,
    input  logic        EX_MEM_CSR_read,
    input  logic [31:0] EX_MEM_CSR,
    mem_access_stage_if.master bus,
    output logic        mem_hold,
    output logic [31:0] MEM_WB_alures,
    output logic [31:0] MEM_WB_memres,
    output logic        MEM_WB_memread,
    output logic        MEM_WB_CSR_read,
    output logic [31:0] MEM_WB_CSR,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic        MEM_WB_fault,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wmask_q, wmask_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             bus_fault_q, bus_fault_d;

    logic        memop;
    logic        is_b;
    logic        is_h;
    logic        trap;
    logic        timeout_hit;
    logic [1:0]  off;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;
    logic        wb_en;
    logic        wb_from_done;
    logic        wb_fault;
    logic [31:0] wb_memres;

    assign memop = EX_MEM_memread | EX_MEM_memwrite;
    // Undefined funct3 encodings fall through to word accesses.
    assign is_b  = (EX_MEM_funct3[1:0] == 2'b00);
    assign is_h  = (EX_MEM_funct3[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = memop & ((is_h & EX_MEM_alures[0]) |
                           (!is_b & !is_h & (EX_MEM_alures[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    // Lane offset at the naturally aligned position for the access size.
    assign off = is_b ? EX_MEM_alures[1:0] :
                 is_h ? {EX_MEM_alures[1], 1'b0} : 2'b00;

    assign st_data = is_b ? {4{EX_MEM_storedata[7:0]}} :
                     is_h ? {2{EX_MEM_storedata[15:0]}} : EX_MEM_storedata;
    assign st_mask = is_b ? (4'b0001 << off) :
                     is_h ? (4'b0011 << off) : 4'hF;

    assign ld_shift = rdata_q >> {off, 3'b000};
    assign ld_ext   = is_b ? {{24{~EX_MEM_funct3[2] & ld_shift[7]}}, ld_shift[7:0]} :
                      is_h ? {{16{~EX_MEM_funct3[2] & ld_shift[15]}}, ld_shift[15:0]} :
                      ld_shift;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rdata_d     = rdata_q;
        bus_fault_d = bus_fault_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (memop && !dbg && !trap) begin
                    state_d     = S_BUSY;
                    req_d       = 1'b1;
                    we_d        = EX_MEM_memwrite;
                    addr_d      = {EX_MEM_alures[31:2], 2'b00};
                    wdata_d     = st_data;
                    wmask_d     = EX_MEM_memwrite ? st_mask : 4'h0;
                    bus_fault_d = 1'b0;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // An ack in the last allowed cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    rdata_d = bus.mem_rdata;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    bus_fault_d = 1'b1;
                    req_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (!dbg) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_hold = !Rst & (((state_q == S_IDLE) & memop & !trap) |
                              (state_q == S_BUSY) |
                              ((state_q == S_DONE) & dbg));

    assign wb_en        = !dbg && !mem_hold;
    assign wb_from_done = (state_q == S_DONE);
    assign wb_fault     = wb_from_done ? bus_fault_q : trap;
    // Non-load and faulted instructions deliver zero as load data.
    assign wb_memres    = (wb_from_done && EX_MEM_memread && !bus_fault_q) ? ld_ext : 32'h0;

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= 32'h0;
            wdata_q         <= 32'h0;
            wmask_q         <= 4'h0;
            rdata_q         <= 32'h0;
            bus_fault_q     <= 1'b0;
            MEM_WB_alures   <= 32'h0;
            MEM_WB_memres   <= 32'h0;
            MEM_WB_memread  <= 1'b0;
            MEM_WB_CSR_read <= 1'b0;
            MEM_WB_CSR      <= 32'h0;
            MEM_WB_rd       <= 5'd0;
            MEM_WB_regwrite <= 1'b0;
            MEM_WB_fault    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rdata_q     <= rdata_d;
            bus_fault_q <= bus_fault_d;
            if (wb_en) begin
                MEM_WB_alures   <= EX_MEM_alures;
                MEM_WB_memres   <= wb_memres;
                MEM_WB_memread  <= EX_MEM_memread;
                MEM_WB_CSR_read <= EX_MEM_CSR_read;
                MEM_WB_CSR      <= EX_MEM_CSR;
                MEM_WB_rd       <= EX_MEM_rd;
                MEM_WB_regwrite <= EX_MEM_regwrite & !wb_fault;
                MEM_WB_fault    <= wb_fault;
            end
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops scored
// against a transaction-level reference model (honours MEM_MISALIGN_TRAP_EN).
module tb_mem_access_stage;
  localparam int TO = 4;
  localparam int W  = 105;

  typedef struct packed {
    logic [31:0] memres;
    logic        regwrite;
    logic        fault;
    logic [7:0]  hold_n;
    logic [7:0]  req_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } exp_t;

  logic clk, Rst, dbg;
  logic [31:0] ex_alures, ex_sd, ex_csr;
  logic [4:0]  ex_rd;
  logic ex_rw, ex_mr, ex_mw, ex_csr_read;
  logic [2:0]  ex_f3;
  logic mem_hold;
  logic [31:0] MEM_WB_alures, MEM_WB_memres, MEM_WB_CSR;
  logic MEM_WB_memread, MEM_WB_CSR_read, MEM_WB_regwrite, MEM_WB_fault;
  logic [4:0]  MEM_WB_rd;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  int obs_hold_n, obs_req_n;
  bit obs_done;
  logic obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_mask;
  logic [W-1:0] obs_wb;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .Rst(Rst), .dbg(dbg),
    .EX_MEM_alures(ex_alures), .EX_MEM_storedata(ex_sd), .EX_MEM_rd(ex_rd),
    .EX_MEM_regwrite(ex_rw), .EX_MEM_memread(ex_mr), .EX_MEM_memwrite(ex_mw),
    .EX_MEM_funct3(ex_f3), .EX_MEM_CSR_read(ex_csr_read), .EX_MEM_CSR(ex_csr),
    .bus(bus), .mem_hold(mem_hold),
    .MEM_WB_alures(MEM_WB_alures), .MEM_WB_memres(MEM_WB_memres),
    .MEM_WB_memread(MEM_WB_memread), .MEM_WB_CSR_read(MEM_WB_CSR_read),
    .MEM_WB_CSR(MEM_WB_CSR), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_regwrite(MEM_WB_regwrite),
    .MEM_WB_fault(MEM_WB_fault), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic exp_t model(input int ack_at, input logic [31:0] rword, input int dbg_n);
    exp_t e;
    int sz, off, lat;
    bit memop, trapped, acked;
    longint v, lim;
    e = '0;
    memop = ex_mr || ex_mw;
    sz = (ex_f3[1:0] == 2'd0) ? 1 : (ex_f3[1:0] == 2'd1) ? 2 : 4;
`ifdef MEM_MISALIGN_TRAP_EN
    trapped = memop && ((int'(ex_alures[1:0]) % sz) != 0);
`else
    trapped = 1'b0;
`endif
    off = (int'(ex_alures[1:0]) / sz) * sz;
    e.addr = {ex_alures[31:2], 2'b00};
    e.we = ex_mw;
    if (ex_mw) begin
      e.mask = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = ex_sd[8*(i % sz) +: 8];
    end
    e.regwrite = ex_rw;
    if (memop && trapped) begin
      e.fault = 1'b1;
      e.regwrite = 1'b0;
    end else if (memop) begin
      acked = (ack_at >= 1) && (ack_at <= TO);
      lat = acked ? ack_at : TO;
      e.req_n = 8'(lat);
      e.hold_n = 8'(1 + ((lat > dbg_n) ? lat : dbg_n));
      e.fault = !acked;
      e.regwrite = ex_rw && acked;
      if (ex_mr && acked) begin
        v = longint'(rword >> (8 * off));
        if (sz < 4) begin
          lim = longint'(1) << (8 * sz);
          v = v % lim;
          if (!ex_f3[2] && v >= lim / 2) v = v - lim;
        end
        e.memres = 32'(v);
      end
    end
    return e;
  endfunction

  function automatic logic [W-1:0] wb_word(input exp_t e);
    return {e.memres, ex_alures, ex_rd, e.regwrite, e.fault, ex_mr, ex_csr_read, ex_csr};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd, input logic rw);
    ex_mr = mr; ex_mw = mw; ex_f3 = f3; ex_alures = a; ex_sd = sd;
    ex_rd = rd; ex_rw = rw;
    ex_csr_read = 1'($urandom_range(0, 1));
    ex_csr = $urandom;
  endtask

  // Runs the currently driven instruction until MEM_WB takes it; acts as memory slave.
  task automatic do_op(input int ack_at, input logic [31:0] rword, input int dbg_n);
    bit upd;
    obs_hold_n = 0; obs_req_n = 0; obs_done = 0;
    for (int c = 0; c < 40 && !obs_done; c++) begin
      dbg = (c >= 1 && c <= dbg_n);
      #1;
      if (mem_hold) obs_hold_n++;
      if (bus.mem_req) begin
        obs_req_n++;
        obs_we = bus.mem_we; obs_addr = bus.mem_addr;
        obs_wdata = bus.mem_wdata; obs_mask = bus.mem_wmask;
        if (obs_req_n == ack_at) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rword;
        end
      end
      upd = !dbg && !mem_hold;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      if (upd) obs_done = 1;
      else @(negedge clk);
    end
    dbg = 1'b0;
    n_cmp++;
    if (!obs_done) begin
      n_err++;
      $display("FAIL op_completion: got no MEM_WB update in 40 cycles, required one");
    end
    @(negedge clk); #1;
    obs_wb = {MEM_WB_memres, MEM_WB_alures, MEM_WB_rd, MEM_WB_regwrite, MEM_WB_fault,
              MEM_WB_memread, MEM_WB_CSR_read, MEM_WB_CSR};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    Rst = 1'b1;
    set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== 70'h0) begin
      n_err++; $display("FAIL reset_bus: got req=%b addr=%h mask=%h, required all 0",
                        bus.mem_req, bus.mem_addr, bus.mem_wmask);
    end
    n_cmp++;
    if ({mem_hold, dbg_state} !== 3'b000) begin
      n_err++; $display("FAIL reset_hold_state: got hold=%b state=%0d, required 0/0", mem_hold, dbg_state);
    end
    n_cmp++;
    if ({MEM_WB_alures, MEM_WB_memres, MEM_WB_CSR, MEM_WB_rd, MEM_WB_memread, MEM_WB_CSR_read,
         MEM_WB_regwrite, MEM_WB_fault} !== 105'h0) begin
      n_err++; $display("FAIL reset_mem_wb: got alures=%h memres=%h rd=%0d rw=%b, required all 0",
                        MEM_WB_alures, MEM_WB_memres, MEM_WB_rd, MEM_WB_regwrite);
    end
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    Rst = 1'b0;
  endtask

  task automatic test_directed;
    set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1);
    do_op(2, 32'hDEADBEEF, 0);
    n_cmp++;
    if (obs_hold_n !== 3) begin
      n_err++; $display("FAIL lw_hold_cycles: got %0d, required 3", obs_hold_n);
    end
    n_cmp++;
    if ({MEM_WB_memres, MEM_WB_regwrite, MEM_WB_fault, obs_addr} !== {32'hDEADBEEF, 2'b10, 32'h100}) begin
      n_err++; $display("FAIL lw_result: got memres=%h rw=%b fault=%b addr=%h, required deadbeef/1/0/100",
                        MEM_WB_memres, MEM_WB_regwrite, MEM_WB_fault, obs_addr);
    end
    set_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1'b1);
    do_op(1, 32'h80123456, 0);
    n_cmp++;
    if (MEM_WB_memres !== 32'hFFFFFF80) begin
      n_err++; $display("FAIL lb_sign: got %h, required ffffff80", MEM_WB_memres);
    end
    set_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd6, 1'b1);
    do_op(1, 32'h80123456, 0);
    n_cmp++;
    if (MEM_WB_memres !== 32'h00000080) begin
      n_err++; $display("FAIL lbu_zero: got %h, required 00000080", MEM_WB_memres);
    end
    set_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, 1'b0);
    do_op(1, 32'h0, 0);
    n_cmp++;
    if ({obs_we, obs_mask, obs_wdata, obs_addr} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h200}) begin
      n_err++; $display("FAIL sh_bus: got we=%b mask=%b wdata=%h addr=%h, required 1/1100/abcdabcd/200",
                        obs_we, obs_mask, obs_wdata, obs_addr);
    end
    n_cmp++;
    if ({MEM_WB_regwrite, MEM_WB_fault} !== 2'b00) begin
      n_err++; $display("FAIL sh_wb: got rw=%b fault=%b, required 0/0", MEM_WB_regwrite, MEM_WB_fault);
    end
  endtask

  task automatic test_timeout;
    set_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd7, 1'b1);
    do_op(0, 32'h0, 0);
    n_cmp++;
    if (obs_req_n !== TO) begin
      n_err++; $display("FAIL timeout_req_cycles: got %0d, required %0d", obs_req_n, TO);
    end
    n_cmp++;
    if ({MEM_WB_fault, MEM_WB_regwrite, MEM_WB_memres} !== {2'b10, 32'h0}) begin
      n_err++; $display("FAIL timeout_wb: got fault=%b rw=%b memres=%h, required 1/0/0",
                        MEM_WB_fault, MEM_WB_regwrite, MEM_WB_memres);
    end
    set_op(1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 5'd9, 1'b1);
    do_op(0, 32'h0, 0);
    n_cmp++;
    if ({obs_hold_n[7:0], MEM_WB_alures, MEM_WB_rd, MEM_WB_regwrite, MEM_WB_fault}
        !== {8'd0, 32'h12345678, 5'd9, 2'b10}) begin
      n_err++; $display("FAIL alu_after_timeout: got hold=%0d alures=%h rd=%0d rw=%b fault=%b, required 0/12345678/9/1/0",
                        obs_hold_n, MEM_WB_alures, MEM_WB_rd, MEM_WB_regwrite, MEM_WB_fault);
    end
  endtask

  task automatic test_misalign;
    logic [31:0] rw;
    rw = $urandom;
    set_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd3, 1'b1);
    do_op(1, rw, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    n_cmp++;
    if ({obs_req_n[7:0], obs_hold_n[7:0], MEM_WB_fault, MEM_WB_regwrite, MEM_WB_memres}
        !== {16'h0, 2'b10, 32'h0}) begin
      n_err++; $display("FAIL misalign_trap: got req=%0d hold=%0d fault=%b rw=%b memres=%h, required 0/0/1/0/0",
                        obs_req_n, obs_hold_n, MEM_WB_fault, MEM_WB_regwrite, MEM_WB_memres);
    end
`else
    n_cmp++;
    if ({obs_addr, MEM_WB_memres, MEM_WB_fault, MEM_WB_regwrite} !== {32'h100, rw, 2'b01}) begin
      n_err++; $display("FAIL misalign_plain: got addr=%h memres=%h fault=%b rw=%b, required 100/%h/0/1",
                        obs_addr, MEM_WB_memres, MEM_WB_fault, MEM_WB_regwrite, rw);
    end
`endif
  endtask

  task automatic test_dbg;
    logic [4:0] prev_rd;
    prev_rd = MEM_WB_rd;
    set_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd21, 1'b1);
    dbg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({bus.mem_req, dbg_state, MEM_WB_rd} !== {3'b000, prev_rd}) begin
        n_err++; $display("FAIL dbg_idle: got req=%b state=%0d rd=%0d, required 0/0/%0d",
                          bus.mem_req, dbg_state, MEM_WB_rd, prev_rd);
      end
      @(posedge clk); @(negedge clk);
    end
    do_op(1, 32'hCAFEF00D, 0);
    n_cmp++;
    if ({obs_req_n[7:0], MEM_WB_memres, MEM_WB_rd} !== {8'd1, 32'hCAFEF00D, 5'd21}) begin
      n_err++; $display("FAIL dbg_release: got req=%0d memres=%h rd=%0d, required 1/cafef00d/21",
                        obs_req_n, MEM_WB_memres, MEM_WB_rd);
    end
    set_op(1'b1, 1'b0, 3'b101, 32'h46, 32'h0, 5'd22, 1'b1);
    do_op(1, 32'h9ABC0000, 4);
    n_cmp++;
    if ({obs_hold_n[7:0], MEM_WB_memres} !== {8'd5, 32'h00009ABC}) begin
      n_err++; $display("FAIL dbg_busy: got hold=%0d memres=%h, required 5/00009abc", obs_hold_n, MEM_WB_memres);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    set_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd4, 1'b1);
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk); @(negedge clk); #1;
      seen = bus.mem_req;
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL rst_mid_start: got req=0, required 1");
    end
    Rst = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({bus.mem_req, dbg_state, mem_hold} !== 4'b0) begin
      n_err++; $display("FAIL rst_mid_drop: got req=%b state=%0d hold=%b, required 0/0/0",
                        bus.mem_req, dbg_state, mem_hold);
    end
    Rst = 1'b0;
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.mem_req, dbg_state, mem_hold, MEM_WB_memres, MEM_WB_fault} !== 37'h0) begin
      n_err++; $display("FAIL late_ack: got req=%b state=%0d hold=%b memres=%h fault=%b, required all 0",
                        bus.mem_req, dbg_state, mem_hold, MEM_WB_memres, MEM_WB_fault);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] kinds [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
    int         acks  [6] = '{0, 1, 1, 0, 3, 0};
    exp_t e;
    logic [31:0] rw;
    for (int i = 0; i < 6; i++) begin
      rw = $urandom;
      set_op(kinds[i] == 2'd1, kinds[i] == 2'd2, (kinds[i] == 2'd1) ? 3'b000 : 3'b010,
             {$urandom_range(0, 255), 2'b00} | ((kinds[i] == 2'd1) ? 32'(i % 4) : 32'h0),
             $urandom, 5'(i + 10), kinds[i] != 2'd2);
      e = model(acks[i], rw, 0);
      exp_q.push_back(wb_word(e));
      do_op(acks[i], rw, 0);
      n_cmp++;
      if (obs_wb !== exp_q[0] || obs_hold_n !== int'(e.hold_n)) begin
        n_err++; $display("FAIL b2b_%0d: got wb=%h hold=%0d, required wb=%h hold=%0d",
                          i, obs_wb, obs_hold_n, exp_q[0], e.hold_n);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_random;
    int kind, ack_at, dbg_n;
    logic [31:0] rw;
    exp_t e;
    logic [W-1:0] exp_w;
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 2);
      ack_at = $urandom_range(0, 6);
      dbg_n = (kind != 0) ? $urandom_range(0, 3) : 0;
      rw = $urandom;
      set_op(kind == 1, kind == 2, 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      e = model(ack_at, rw, dbg_n);
      exp_q.push_back(wb_word(e));
      do_op(ack_at, rw, dbg_n);
      exp_w = exp_q.pop_front();
      n_cmp++;
      if (obs_wb !== exp_w) begin
        n_err++; $display("FAIL rand_wb_%0d: got %h, required %h", i, obs_wb, exp_w);
      end
      n_cmp++;
      if ({8'(obs_hold_n), 8'(obs_req_n)} !== {e.hold_n, e.req_n}) begin
        n_err++; $display("FAIL rand_timing_%0d: got hold=%0d req=%0d, required hold=%0d req=%0d",
                          i, obs_hold_n, obs_req_n, e.hold_n, e.req_n);
      end
      if (e.req_n != 0) begin
        n_cmp++;
        if ({obs_we, obs_addr, obs_wdata & {32{e.we}}, obs_mask} !== {e.we, e.addr, e.wdata, e.mask}) begin
          n_err++; $display("FAIL rand_bus_%0d: got we=%b addr=%h wdata=%h mask=%b, required %b/%h/%h/%b",
                            i, obs_we, obs_addr, obs_wdata, obs_mask, e.we, e.addr, e.wdata, e.mask);
        end
      end
    end
  endtask

  initial begin
    dbg = 1'b0;
    Rst = 1'b1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    test_reset();
    test_directed();
    test_timeout();
    test_misalign();
    test_dbg();
    test_reset_mid();
    test_back_to_back();
    test_random();
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
